// File: rtl/gate_truth_checker.sv
// gate_truth_checker
// Drives all four {A,B} combinations into a 2-input gate under test, holds each
// one for a programmable settle time, then samples Q against an expected truth
// table. Reports per-combination sticky mismatch flags, a saturating mismatch
// count and an overall pass flag at the end of each run.
//
// Parameters
//   EXPECTED      expected Q per index {A,B}; bit[idx] is Q for A=idx[1], B=idx[0]
//   SETTLE_CYCLES cycles the inputs are held before Q is sampled (0 acts as 1)
//   REPEAT        full 4-combination sweeps per start (0 acts as 1)
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      run request, sampled only in IDLE (ignored while done is high)
//   dut_a      drive to the gate's A input
//   dut_b      drive to the gate's B input
//   dut_q      gate output under test
//   busy       high from the cycle after an accepted start until done
//   done       one-cycle pulse at the end of a run
//   pass       result of the last run, held until the next accepted start
//   fail_vec   sticky per-index mismatch flags for the last run
//   err_count  total mismatches in the last run, saturating at 255
//
// Optional feature macro: GATE_CHECKER_SYNC_EN
//   When defined, dut_q passes through a two-flop synchronizer before the
//   compare and each SETTLE phase lasts two extra cycles to cover its delay.
module gate_truth_checker #(
  parameter logic [3:0] EXPECTED      = 4'b1000,
  parameter int         SETTLE_CYCLES = 2,
  parameter int         REPEAT        = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       dut_a,
  output logic       dut_b,
  input  logic       dut_q,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_vec,
  output logic [7:0] err_count
);

  localparam int S_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
  localparam int R_EFF = (REPEAT < 1) ? 1 : REPEAT;
`ifdef GATE_CHECKER_SYNC_EN
  localparam int SETTLE_EXIT = S_EFF + 2;
`else
  localparam int SETTLE_EXIT = S_EFF;
`endif
  // Settle counter is one bit wider than 8 so S+2 (up to 257) stays reachable.
  localparam logic [8:0] SETTLE_LAST = 9'(SETTLE_EXIT - 1);
  localparam logic [7:0] SWEEP_LAST  = 8'(R_EFF - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_accept;
  logic [1:0]  r_idx;
  logic [8:0]  r_settle;
  logic [7:0]  r_sweep;
  logic        r_a;
  logic        r_b;
  logic        r_busy;
  logic        r_done;
  logic        r_pass;
  logic [3:0]  r_fail;
  logic [7:0]  r_err;
  logic        w_q;
  logic        w_exp;
  logic        w_mismatch;

`ifdef GATE_CHECKER_SYNC_EN
  logic r_sync1;
  logic r_sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= dut_q;
      r_sync2 <= r_sync1;
    end
  end

  assign w_q = r_sync2;
`else
  assign w_q = dut_q;
`endif

  assign w_exp      = EXPECTED[r_idx];
  // Case inequality so an X/Z on the gate output is scored as a mismatch.
  assign w_mismatch = (w_q !== w_exp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        // A start coinciding with the done pulse is not a new request.
        if (start && !r_done) begin
          w_state_nxt = SETTLE;
          w_accept    = 1'b1;
        end
      end
      SETTLE: begin
        if (r_settle == SETTLE_LAST) w_state_nxt = SAMPLE;
      end
      SAMPLE: begin
        if ((r_idx != 2'd3) || (r_sweep < SWEEP_LAST)) w_state_nxt = SETTLE;
        else                                            w_state_nxt = DONE;
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx    <= 2'd0;
      r_settle <= 9'd0;
      r_sweep  <= 8'd0;
      r_a      <= 1'b0;
      r_b      <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
      r_fail   <= 4'd0;
      r_err    <= 8'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_idx    <= 2'd0;
            r_settle <= 9'd0;
            r_sweep  <= 8'd0;
            r_a      <= 1'b0;
            r_b      <= 1'b0;
            r_busy   <= 1'b1;
            r_pass   <= 1'b0;
            r_fail   <= 4'd0;
            r_err    <= 8'd0;
          end
        end
        SETTLE: begin
          r_settle <= r_settle + 9'd1;
        end
        SAMPLE: begin
          if (w_mismatch) begin
            r_fail[r_idx] <= 1'b1;
            if (r_err != 8'hFF) r_err <= r_err + 8'd1;
          end
          if (r_idx != 2'd3) begin
            r_idx        <= r_idx + 2'd1;
            {r_a, r_b}   <= r_idx + 2'd1;
            r_settle     <= 9'd0;
          end else if (r_sweep < SWEEP_LAST) begin
            r_sweep  <= r_sweep + 8'd1;
            r_idx    <= 2'd0;
            r_a      <= 1'b0;
            r_b      <= 1'b0;
            r_settle <= 9'd0;
          end
        end
        DONE: begin
          // r_fail already holds the final sample, written on the SAMPLE edge.
          r_done <= 1'b1;
          r_busy <= 1'b0;
          r_pass <= (r_fail == 4'd0);
          r_a    <= 1'b0;
          r_b    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign dut_a     = r_a;
  assign dut_b     = r_b;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign fail_vec  = r_fail;
  assign err_count = r_err;

endmodule
